// File: rtl/bf_pass_sequencer_pkg.sv
// Bellman-Ford pass sequencer shared types.
// State encoding, default widths, distance infinity.
package bf_pass_sequencer_pkg;

  localparam int EDGE_W_DEF = 13;
  localparam int VERT_W_DEF = 13;
  localparam logic [15:0] DIST_INF = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_PASS,
    S_DRAIN,
    S_CHECK,
    S_DRAIN_C,
    S_DONE,
    S_NEG
  } state_t;

  function automatic logic is_issue(state_t s);
    return (s == S_PASS) || (s == S_CHECK);
  endfunction

  function automatic logic is_busy(state_t s);
    return !(s inside {S_IDLE, S_DONE, S_NEG});
  endfunction

endpackage

// File: rtl/bf_pass_sequencer_if.sv
// Edge issue / relax result link between
// the pass sequencer and the relax datapath.
interface bf_pass_sequencer_if #(
  parameter int EDGE_W = bf_pass_sequencer_pkg::EDGE_W_DEF
);
  logic [EDGE_W-1:0] edge_idx;
  logic              edge_valid;
  logic              edge_ready;
  logic              res_valid;
  logic              res_updated;

  modport master (
    output edge_idx,
    output edge_valid,
    input  edge_ready,
    input  res_valid,
    input  res_updated
  );

  modport slave (
    input  edge_idx,
    input  edge_valid,
    output edge_ready,
    output res_valid,
    output res_updated
  );
endinterface

// File: rtl/bf_inflight_ctr.sv
// Credit counter for relax results in flight.
// Results with nothing outstanding are flagged, not counted.
module bf_inflight_ctr #(
  parameter int MAX_INFL = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic full,
  output logic zero_nx,
  output logic uflow
);
  localparam int CW = $clog2(MAX_INFL + 1);
  localparam logic [CW-1:0] MAXV = CW'(MAX_INFL);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nx;
  logic          dec_ok;

  assign uflow   = dec && (cnt == '0);
  assign dec_ok  = dec && (cnt != '0);
  assign full    = (cnt >= MAXV);
  assign zero_nx = (cnt_nx == '0);

  // next count: same-cycle issue and result cancel
  always_comb begin
    cnt_nx = cnt;
    unique case ({inc, dec_ok})
      2'b10:   cnt_nx = cnt + 1'b1;
      2'b01:   cnt_nx = cnt - 1'b1;
      default: cnt_nx = cnt;
    endcase
  end

  // count register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt <= '0;
    else        cnt <= cnt_nx;
  end
endmodule

// File: rtl/bf_pass_sequencer.sv
// Bellman-Ford iteration controller: init, relax passes,
// early exit, final negative-cycle check pass.
module bf_pass_sequencer
  import bf_pass_sequencer_pkg::*;
#(
  parameter int EDGE_W   = EDGE_W_DEF,
  parameter int VERT_W   = VERT_W_DEF,
  parameter int MAX_INFL = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [VERT_W-1:0] num_vertices,
  input  logic [EDGE_W-1:0] num_edges,
  output logic              init_go,
  input  logic              init_done,
  bf_pass_sequencer_if.master eif,
  output logic [VERT_W-1:0] pass_num,
  output logic              busy,
  output logic              Finish,
  output logic              NegCycle,
  output logic              proto_err
);
  state_t            st, st_nx;
  logic [EDGE_W:0]   idx, idx_nx;
  logic [EDGE_W:0]   e_r, e_nx;
  logic [VERT_W-1:0] v_r, v_nx;
  logic [VERT_W-1:0] pn_nx;
  logic              chg, chg_nx, chg_in;
  logic              go_nx, arm, arm_nx, perr_nx;
  logic              issue, full, zero_nx, uflow;
  logic              drain;

  bf_inflight_ctr #(
    .MAX_INFL (MAX_INFL)
  ) u_ctr (
    .clock   (clock),
    .reset   (reset),
    .inc     (issue),
    .dec     (eif.res_valid),
    .full    (full),
    .zero_nx (zero_nx),
    .uflow   (uflow)
  );

  assign eif.edge_valid = is_issue(st) && (idx < e_r) && !full;
  assign eif.edge_idx   = idx[EDGE_W-1:0];
  assign issue          = eif.edge_valid && eif.edge_ready;
  assign chg_in         = eif.res_valid && eif.res_updated;
  assign drain          = (is_issue(st) && (idx == e_r))
                       || (st == S_DRAIN) || (st == S_DRAIN_C);
  assign busy           = is_busy(st);
  assign Finish         = (st == S_DONE);
  assign NegCycle       = (st == S_NEG);

  // next state, counters and flags
  always_comb begin
    st_nx   = st;
    idx_nx  = idx;
    e_nx    = e_r;
    v_nx    = v_r;
    pn_nx   = pass_num;
    chg_nx  = chg | chg_in;
    go_nx   = 1'b0;
    arm_nx  = arm;
    perr_nx = proto_err | (uflow & arm);
    unique case (st)
      S_IDLE, S_DONE, S_NEG: begin
        if (start) begin
          st_nx   = S_INIT;
          v_nx    = num_vertices;
          e_nx    = {1'b0, num_edges};
          pn_nx   = '0;
          idx_nx  = '0;
          go_nx   = 1'b1;
          arm_nx  = 1'b1;
          perr_nx = 1'b0;
        end
      end
      S_INIT: begin
        if (init_done) begin
          if ((v_r <= VERT_W'(1)) || (e_r == '0)) begin
            st_nx = S_DONE;
          end else begin
            st_nx  = S_PASS;
            pn_nx  = VERT_W'(1);
            idx_nx = '0;
            chg_nx = 1'b0;
          end
        end
      end
      S_PASS, S_DRAIN: begin
        if (issue) idx_nx = idx + 1'b1;
        if (drain) begin
          if (!zero_nx) begin
            st_nx = S_DRAIN;
          end else if (!chg_nx) begin
            st_nx = S_DONE;
          end else begin
            idx_nx = '0;
            chg_nx = 1'b0;
            if (pass_num == v_r - 1'b1) begin
              st_nx = S_CHECK;
              pn_nx = v_r;
            end else begin
              st_nx = S_PASS;
              pn_nx = pass_num + 1'b1;
            end
          end
        end
      end
      S_CHECK, S_DRAIN_C: begin
        if (issue) idx_nx = idx + 1'b1;
        if (drain) begin
          if (!zero_nx) st_nx = S_DRAIN_C;
          else if (chg_nx) st_nx = S_NEG;
          else st_nx = S_DONE;
        end
      end
      default: st_nx = S_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st        <= S_IDLE;
      idx       <= '0;
      e_r       <= '0;
      v_r       <= '0;
      pass_num  <= '0;
      chg       <= 1'b0;
      init_go   <= 1'b0;
      arm       <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      st        <= st_nx;
      idx       <= idx_nx;
      e_r       <= e_nx;
      v_r       <= v_nx;
      pass_num  <= pn_nx;
      chg       <= chg_nx;
      init_go   <= go_nx;
      arm       <= arm_nx;
      proto_err <= perr_nx;
    end
  end
endmodule

// File: tb/tb_bf_pass_sequencer.sv
// Directed bench for bf_pass_sequencer with a
// relax datapath responder and a vector table.
module tb_bf_pass_sequencer;
  localparam int MAXI = 4;

  logic        clock;
  logic        reset;
  logic        start;
  logic [12:0] num_vertices;
  logic [12:0] num_edges;
  logic        init_go;
  logic        init_done;
  logic [12:0] pass_num;
  logic        busy;
  logic        Finish;
  logic        NegCycle;
  logic        proto_err;

  bf_pass_sequencer_if #(.EDGE_W(13)) eif ();

  bf_pass_sequencer #(
    .EDGE_W   (13),
    .VERT_W   (13),
    .MAX_INFL (MAXI)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .num_vertices (num_vertices),
    .num_edges    (num_edges),
    .init_go      (init_go),
    .init_done    (init_done),
    .eif          (eif),
    .pass_num     (pass_num),
    .busy         (busy),
    .Finish       (Finish),
    .NegCycle     (NegCycle),
    .proto_err    (proto_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask

  // responder configuration (written by main only)
  int       cur_e = 0;
  logic [7:0] mask = '0;
  bit       rnd = 0;
  int       maxdel = 0;
  int       gen = 0;
  int       spur_gen = 0;

  // responder observations (written by responder only)
  int cyc = 0;
  int last_res = -100;
  int edges_m = 0;
  int ord_err = 0;
  int pn_err = 0;
  int pass_m = 0;
  int exp_idx = 0;
  int outst_m = 0;
  int max_out = 0;

  typedef struct { int due; bit upd; } rs_t;
  rs_t q[$];

  // relax datapath model: random ready, delayed in-order results
  initial begin
    int  seen_gen;
    int  seen_spur;
    bit  hs;
    bit  legit;
    bit  u;
    seen_gen = 0;
    seen_spur = 0;
    legit = 0;
    eif.edge_ready = 1'b0;
    eif.res_valid = 1'b0;
    eif.res_updated = 1'b0;
    forever begin
      @(negedge clock);
      if (gen != seen_gen) begin
        seen_gen = gen;
        q.delete();
        edges_m = 0; ord_err = 0; pn_err = 0;
        pass_m = 0; exp_idx = 0;
        outst_m = 0; max_out = 0;
        legit = 0;
      end
      hs = eif.edge_valid && eif.edge_ready;
      outst_m = outst_m + int'(hs) - int'(legit);
      if (outst_m > max_out) max_out = outst_m;
      if (hs) begin
        if (eif.edge_idx != 13'(exp_idx)) ord_err++;
        if (pass_num != 13'(pass_m + 1)) pn_err++;
        u = (pass_m < 8) && mask[pass_m[2:0]] && (exp_idx == 0);
        q.push_back('{cyc + 1 + int'($urandom_range(maxdel, 0)), u});
        edges_m++;
        exp_idx++;
        if (exp_idx == cur_e) begin
          exp_idx = 0;
          pass_m++;
        end
      end
      @(posedge clock);
      #1;
      cyc++;
      eif.edge_ready = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
      eif.res_valid = 1'b0;
      eif.res_updated = 1'b0;
      legit = 0;
      if (spur_gen != seen_spur) begin
        seen_spur = spur_gen;
        eif.res_valid = 1'b1;
      end else if (q.size() > 0 && q[0].due <= cyc) begin
        eif.res_valid = 1'b1;
        eif.res_updated = q[0].upd;
        legit = 1;
        last_res = cyc;
        void'(q.pop_front());
      end
    end
  end

  typedef struct {
    int         v;
    int         e;
    logic [7:0] mask;
    bit         rnd;
    int         maxdel;
    int         poke;
    bit         fin;
    bit         neg;
    int         edges;
  } vec_t;

  vec_t tbl[8];

  task automatic kick(input int v, input int e, input bit expe,
                      input string nm);
    @(posedge clock);
    #1;
    num_vertices = 13'(v);
    num_edges = 13'(e);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    @(negedge clock);
    chk({nm, ".init_go"}, int'(init_go), 1);
    chk({nm, ".perr_clr"}, int'(proto_err), 0);
    @(posedge clock);
    #1;
    init_done = 1'b1;
    @(posedge clock);
    #1;
    init_done = 1'b0;
    @(negedge clock);
    chk({nm, ".go_pulse"}, int'(init_go), 0);
    if (expe) chk({nm, ".first_ev"}, int'(eif.edge_valid), 1);
    else chk({nm, ".fin_fast"}, int'(Finish), 1);
  endtask

  task automatic run_case(input vec_t t, input string nm);
    bit done;
    cur_e = t.e;
    mask = t.mask;
    rnd = t.rnd;
    maxdel = t.maxdel;
    gen++;
    @(negedge clock);
    kick(t.v, t.e, t.edges > 0, nm);
    done = 0;
    for (int k = 0; k < 5000; k++) begin
      if (!busy) begin
        done = 1;
        break;
      end
      start = (k == t.poke);
      num_vertices = (k == t.poke) ? 13'd2 : num_vertices;
      num_edges = (k == t.poke) ? 13'd1 : num_edges;
      @(negedge clock);
    end
    start = 1'b0;
    chk({nm, ".done"}, int'(done), 1);
    if (t.edges > 0) chk({nm, ".lat"}, cyc - last_res, 1);
    chk({nm, ".finish"}, int'(Finish), int'(t.fin));
    chk({nm, ".negcyc"}, int'(NegCycle), int'(t.neg));
    chk({nm, ".edges"}, edges_m, t.edges);
    chk({nm, ".order"}, ord_err, 0);
    chk({nm, ".passnum"}, pn_err, 0);
    chk({nm, ".maxout"}, int'(max_out > MAXI), 0);
    chk({nm, ".perr"}, int'(proto_err), 0);
  endtask

  initial begin
    bit reached;
    vec_t clean;
    tbl[0] = '{4, 5, 8'h01, 0, 0, -1, 1, 0, 10};
    tbl[1] = '{3, 3, 8'hFF, 0, 0, -1, 0, 1, 9};
    tbl[2] = '{4, 0, 8'hFF, 0, 0, -1, 1, 0, 0};
    tbl[3] = '{1, 5, 8'hFF, 0, 0, -1, 1, 0, 0};
    tbl[4] = '{5, 7, 8'h03, 1, 6, 15, 1, 0, 21};
    tbl[5] = '{3, 4, 8'h03, 1, 6, -1, 1, 0, 12};
    tbl[6] = '{2, 1, 8'hFF, 1, 3, -1, 0, 1, 2};
    tbl[7] = '{6, 6, 8'h00, 1, 6, -1, 1, 0, 6};

    reset = 1'b0;
    start = 1'b0;
    init_done = 1'b0;
    num_vertices = '0;
    num_edges = '0;
    #3;
    chk("rst.flags",
        int'({busy, Finish, NegCycle, proto_err, init_go, eif.edge_valid}), 0);
    chk("rst.pass_num", int'(pass_num), 0);
    chk("rst.edge_idx", int'(eif.edge_idx), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;

    spur_gen++;
    repeat (3) @(negedge clock);
    chk("spur_postrst.perr", int'(proto_err), 0);

    for (int i = 0; i < 8; i++) run_case(tbl[i], $sformatf("vec%0d", i));

    spur_gen++;
    repeat (3) @(negedge clock);
    chk("spur_idle.perr", int'(proto_err), 1);
    chk("spur_idle.busy", int'(busy), 0);

    cur_e = 5;
    mask = 8'hFF;
    rnd = 1;
    maxdel = 6;
    gen++;
    @(negedge clock);
    kick(4, 5, 1, "mid");
    reached = 0;
    for (int k = 0; k < 2000; k++) begin
      if (pass_m == 1 && exp_idx >= 2) begin
        reached = 1;
        break;
      end
      @(negedge clock);
    end
    chk("mid.reach_pass2", int'(reached), 1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid.rst_flags",
        int'({busy, Finish, NegCycle, proto_err, init_go, eif.edge_valid}), 0);
    chk("mid.rst_pass", int'(pass_num), 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    repeat (10) @(negedge clock);
    chk("mid.inflight_perr", int'(proto_err), 0);
    spur_gen++;
    repeat (3) @(negedge clock);
    chk("mid.spur_perr", int'(proto_err), 0);
    chk("mid.busy", int'(busy), 0);

    clean = '{4, 5, 8'h01, 1, 4, -1, 1, 0, 10};
    run_case(clean, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
